// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs from the pipeline plus the instruction
// memory request and the decode-side {pc, bubble} pair.
// There is no valid/ready pair on this bus. mem_re qualifies mem_addr in
// every cycle. bubble_out=0 marks pc_out as carrying a real instruction.
// stall is the only backpressure: the whole front end holds while it is high.
interface fetch_stage_if;
    logic        stall;
    logic        halt;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] pc_out;
    logic        bubble_out;

    modport master (
        input  stall, halt, flush, branch_target,
        output mem_addr, mem_re, pc_out, bubble_out
    );

    modport slave (
        output stall, halt, flush, branch_target,
        input  mem_addr, mem_re, pc_out, bubble_out
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC and issues instruction memory reads.
// A MEM_LATENCY-deep delay line of {pc, valid} keeps pc_out/bubble_out
// aligned with the memory's returned word.
// Optional macro FETCH_PERF_EN adds the fetch_count and squash_count counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        squash_count
`endif
);
    localparam int LAST = MEM_LATENCY - 1;

    logic [31:0]            pc_f;
    logic [31:0]            stage_pc [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] stage_valid;
    logic [31:0]            target;

    // Branch targets are word aligned by dropping the low bits.
    assign target = {bus.branch_target[31:2], 2'b00};

    // Fetch PC and delay line. halt freezes everything, flush beats stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            stage_valid <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                stage_pc[k] <= RESET_PC;
            end
        end else if (!bus.halt) begin
            if (bus.flush) begin
                pc_f        <= target;
                stage_valid <= '0;
                for (int k = 0; k < MEM_LATENCY; k++) begin
                    stage_pc[k] <= target;
                end
            end else if (!bus.stall) begin
                pc_f           <= pc_f + 32'd4;
                stage_pc[0]    <= pc_f;
                stage_valid[0] <= 1'b1;
                for (int k = 1; k < MEM_LATENCY; k++) begin
                    stage_pc[k]    <= stage_pc[k-1];
                    stage_valid[k] <= stage_valid[k-1];
                end
            end
        end
    end

    // While stalled, the same address is re-presented so that memory re-issues the read.
    assign bus.mem_addr   = pc_f;
    assign bus.mem_re     = !bus.halt && !rst;
    assign bus.pc_out     = stage_pc[LAST];
    assign bus.bubble_out = !stage_valid[LAST];

`ifdef FETCH_PERF_EN
    logic [31:0] valid_in_flight;

    // Count of valid stages that a flush in this cycle would squash.
    always_comb begin
        valid_in_flight = '0;
        for (int k = 0; k < MEM_LATENCY; k++) begin
            if (stage_valid[k]) begin
                valid_in_flight = valid_in_flight + 32'd1;
            end
        end
    end

    // Performance counters. Both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else if (!bus.halt) begin
            if (stage_valid[LAST] && !bus.stall) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bus.flush) begin
                squash_count <= squash_count + valid_in_flight;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. Two instances share one stimulus stream:
// u0 uses defaults (RESET_PC=0, latency 2) and u1 uses RESET_PC=0xFFFF_FFF8
// with latency 3. Each instance is checked against its own reference model.
module tb_fetch_stage;
  logic clk;
  logic rst;
  logic stall;
  logic halt;
  logic flush;
  logic [31:0] branch_target;

  fetch_stage_if b0 ();
  fetch_stage_if b1 ();

  assign b0.stall = stall;
  assign b0.halt = halt;
  assign b0.flush = flush;
  assign b0.branch_target = branch_target;
  assign b1.stall = stall;
  assign b1.halt = halt;
  assign b1.flush = flush;
  assign b1.branch_target = branch_target;

`ifdef FETCH_PERF_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(2)) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc0), .squash_count(sc0)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(3)) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc1), .squash_count(sc1)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Reference model. The history queue holds every {pc, valid} issued
  // toward decode. The front entry is the one that the memory returns now.
  logic [31:0] rst_pc_m [2];
  int          lat_m [2];
  logic [31:0] pcf_m [2];
  logic [32:0] hist_q [2][$];
  logic [31:0] fc_m [2];
  logic [31:0] sc_m [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pcf_m[i] = rst_pc_m[i];
      hist_q[i].delete();
      for (int k = 0; k < lat_m[i]; k++) hist_q[i].push_back({rst_pc_m[i], 1'b0});
      fc_m[i] = '0;
      sc_m[i] = '0;
    end
  endtask

  task automatic model_step(input logic s, input logic h, input logic f, input logic [31:0] bt);
    logic [31:0] t;
    int nv;
    t = {bt[31:2], 2'b00};
    for (int i = 0; i < 2; i++) begin
      if (!h) begin
        if (hist_q[i][0][0] && !s) fc_m[i] = fc_m[i] + 1;
        if (f) begin
          nv = 0;
          foreach (hist_q[i][k]) if (hist_q[i][k][0]) nv++;
          sc_m[i] = sc_m[i] + 32'(nv);
          hist_q[i].delete();
          for (int k = 0; k < lat_m[i]; k++) hist_q[i].push_back({t, 1'b0});
          pcf_m[i] = t;
        end else if (!s) begin
          hist_q[i].push_back({pcf_m[i], 1'b1});
          void'(hist_q[i].pop_front());
          pcf_m[i] = pcf_m[i] + 32'd4;
        end
      end
    end
  endtask

  // scoreboard comparison of both instances against the model
  task automatic check_all(input logic exp_re);
    check_eq("u0 mem_addr", b0.mem_addr, pcf_m[0]);
    check_eq("u0 mem_re", 32'(b0.mem_re), 32'(exp_re));
    check_eq("u0 pc_out", b0.pc_out, hist_q[0][0][32:1]);
    check_eq("u0 bubble_out", 32'(b0.bubble_out), 32'(!hist_q[0][0][0]));
    check_eq("u1 mem_addr", b1.mem_addr, pcf_m[1]);
    check_eq("u1 mem_re", 32'(b1.mem_re), 32'(exp_re));
    check_eq("u1 pc_out", b1.pc_out, hist_q[1][0][32:1]);
    check_eq("u1 bubble_out", 32'(b1.bubble_out), 32'(!hist_q[1][0][0]));
`ifdef FETCH_PERF_EN
    check_eq("u0 fetch_count", fc0, fc_m[0]);
    check_eq("u0 squash_count", sc0, sc_m[0]);
    check_eq("u1 fetch_count", fc1, fc_m[1]);
    check_eq("u1 squash_count", sc1, sc_m[1]);
`endif
  endtask

  // driver: apply inputs for one cycle, check, then advance the model
  task automatic step(input logic s, input logic h, input logic f, input logic [31:0] bt);
    stall = s;
    halt = h;
    flush = f;
    branch_target = bt;
    #1;
    check_all(!h);
    @(posedge clk);
    model_step(s, h, f, bt);
    @(negedge clk);
  endtask

  task automatic clean(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_pc_m[0] = 32'h0000_0000;
    rst_pc_m[1] = 32'hFFFF_FFF8;
    lat_m[0] = 2;
    lat_m[1] = 3;
    rst = 1'b1;
    stall = 1'b0;
    halt = 1'b0;
    flush = 1'b0;
    branch_target = '0;
    model_reset();
    #1;
    check_all(1'b0);
    repeat (2) @(negedge clk);
    check_all(1'b0);
    rst = 1'b0;

    // clean start, stall in cycles 5-7, then flush to a misaligned target
    clean(5);
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0, 32'h0);
    clean(2);
    step(1'b0, 1'b0, 1'b1, 32'h0000_1003);
    clean(9);
    // flush wins over stall
    step(1'b1, 1'b0, 1'b1, 32'h0000_2002);
    clean(4);
    // halt dominates flush and stall
    step(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    clean(3);
    // back-to-back flushes, last one wins
    step(1'b0, 1'b0, 1'b1, 32'h0000_4000);
    step(1'b0, 1'b0, 1'b1, 32'h0000_5001);
    clean(5);
    // wrap through 0xFFFF_FFFC -> 0
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4);
    clean(8);

    // randomized phase
    for (int j = 0; j < 400; j++) begin
      logic s, h, f;
      logic [31:0] bt;
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 7) == 0);
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(s, h, f, bt);
    end

    // asynchronous reset mid-stream: outputs revert before any clock edge
    clean(6);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(1'b0);
    @(negedge clk);
    check_all(1'b0);
    rst = 1'b0;
    // ten clean fetches, then a flush with valid stages in flight
    clean(12);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0800);
    clean(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end producer for the decode stage.
- Owns the program counter and issues instruction addresses to the instruction memory, which has a fixed read latency.
- Delivers a PC and bubble flag aligned with the returned instruction word (decode's mem_out_0), so decode sees a matched {mem_out_0, pc_in, bubble_in} triple each cycle.
- Handles redirect on taken branch (flush), pipeline stall and halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- MEM_LATENCY, 2: instruction memory read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold front end; same stall signal decode receives.
- halt  input  1  freeze entire stage; halt dominates stall and flush.
- flush  input  1  redirect request from branch resolution.
- branch_target  input  32  redirect PC, sampled when flush=1.
- mem_addr  output  32  instruction memory read address.
- mem_re  output  1  instruction memory read enable.
- pc_out  output  32  PC of the instruction currently on mem_out_0; goes to decode pc_in.
- bubble_out  output  1  1 = current memory output is not a valid instruction; goes to decode bubble_in.

Behaviour:
- State:
  - pc_f: next fetch PC.
  - Delay line of MEM_LATENCY stages, each holding {pc_k, valid_k}.
  - pc_out = pc of the last stage; bubble_out = !valid of the last stage.
- mem_addr = pc_f (combinational). mem_re = !halt && !rst.
- Reset (async, while rst=1):
  - pc_f = RESET_PC.
  - All pc_k = RESET_PC; all valid_k = 0.
  - Resulting outputs: pc_out = RESET_PC, bubble_out = 1, mem_addr = RESET_PC, mem_re = 0.
- Normal cycle (no halt, no stall, no flush):
  - pc_f <= pc_f + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Stage 1 <= {pc_f, 1}; stage k <= stage k-1.
- Latency:
  - The address presented in cycle C appears on pc_out with bubble_out=0 in cycle C+MEM_LATENCY, the same cycle its data appears on mem_out_0.
  - After rst deasserts before cycle 0: RESET_PC reaches pc_out in cycle MEM_LATENCY; bubble_out=1 in cycles 0..MEM_LATENCY-1.
- Stall (stall=1, halt=0, flush=0):
  - pc_f and all stages hold.
  - mem_addr keeps presenting the same address (re-issue).
  - Decode buffers the returned word itself.
- Flush (flush=1, halt=0), in cycle N; flush wins over stall:
  - pc_f <= {branch_target[31:2], 2'b00}.
  - All valid_k <= 0; all pc_k <= {branch_target[31:2], 2'b00}.
  - Cycle N+1: mem_addr = target.
  - bubble_out=1 in cycles N+1..N+MEM_LATENCY.
  - Cycle N+1+MEM_LATENCY: pc_out = target, bubble_out = 0.
- Flush on consecutive cycles: the last flush wins, and the squash window restarts.
- Halt (halt=1): all registers hold regardless of stall/flush; mem_re=0; outputs frozen. Deasserting halt resumes from the held state.
- Misaligned branch_target: bits [1:0] are discarded, never trapped.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs fetch_count[31:0] and squash_count[31:0], both reset to 0, both wrap at 2^32.
  - fetch_count increments each cycle the last stage is valid and stall=0 and halt=0.
  - squash_count increments by the number of valid stages cleared by each flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then release with no stall, MEM_LATENCY=2 -> mem_addr 0,4,8,... from cycle 0; pc_out=0/bubble_out=0 in cycle 2, pc_out=4 in cycle 3; bubble_out=1 in cycles 0-1.
2. Stall high for cycles 5-7 -> mem_addr, pc_out and bubble_out constant across cycles 5-8; sequence resumes +4 per cycle from cycle 8 with no PC skipped or duplicated at the output.
3. flush=1, branch_target=0x0000_1003 in cycle 10 -> mem_addr=0x1000 in cycle 11; bubble_out=1 in cycles 11-12; pc_out=0x1000, bubble_out=0 in cycle 13; 0x1004 in cycle 14.
4. flush and stall both high in cycle 20 -> redirect taken exactly as in scenario 3; halt, flush and stall all high -> nothing changes and mem_re=0.
5. RESET_PC=0xFFFF_FFF8 -> pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst asserted mid-stream -> outputs return to reset values immediately, without waiting for a clock edge.
6. FETCH_PERF_EN defined: 10 clean fetches, then a flush with 2 valid stages in flight -> fetch_count=10, squash_count=2.
